// File: rtl/saradc_11b_dig_dither_ctrl.sv
// -----------------------------------------------------------------------------
// saradc_11b_dig_dither_ctrl
//
// Conversion sequencer for the 11-bit SAR ADC digital section. It owns the
// 6-bit dither LFSR and handles each conversion request as follows:
//   - capture the current LFSR word and drive it to the dither DAC;
//   - step the LFSR exactly once;
//   - launch the SAR core and wait for completion, with a timeout;
//   - subtract the applied dither from the raw code;
//   - return a saturated RES_W-bit result.
//
// Ports:
//   clk           rising-edge clock
//   nres          asynchronous active-low reset
//   start_i       conversion request, honoured only while idle
//   dither_en_i   dither enable, sampled on the start-accept edge
//   busy_o        conversion in progress
//   lfsr_en_o     one-cycle LFSR step pulse
//   lfsr_val_i    current LFSR value
//   dac_dither_o  dither code applied to the DAC
//   sar_start_o   one-cycle SAR launch pulse
//   sar_done_i    SAR complete pulse, sar_result_i valid in the same cycle
//   sar_result_i  raw unsigned SAR code
//   result_o      corrected result, held until the next valid_o
//   valid_o       one-cycle result strobe
//   sat_o         saturation flag, updated together with valid_o
//   timeout_o     one-cycle abort strobe
// -----------------------------------------------------------------------------
module saradc_11b_dig_dither_ctrl #(
  parameter int RES_W       = 11,
  parameter int RAW_W       = 12,
  parameter int DITHER_W    = 6,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                nres,
  input  logic                start_i,
  input  logic                dither_en_i,
  output logic                busy_o,
  output logic                lfsr_en_o,
  input  logic [DITHER_W-1:0] lfsr_val_i,
  output logic [DITHER_W-1:0] dac_dither_o,
  output logic                sar_start_o,
  input  logic                sar_done_i,
  input  logic [RAW_W-1:0]    sar_result_i,
  output logic [RES_W-1:0]    result_o,
  output logic                valid_o,
  output logic                sat_o,
  output logic                timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  // The counter holds 0 during the first WAIT cycle, so this value marks the
  // last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [RES_W-1:0] RES_MAX  = {RES_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DITHER_W-1:0] dither_q, dither_d;
  logic                busy_q, busy_d;
  logic                lfsr_en_q, lfsr_en_d;
  logic [DITHER_W-1:0] dac_q, dac_d;
  logic                sar_start_q, sar_start_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                valid_q, valid_d;
  logic                sat_q, sat_d;
  logic                timeout_q, timeout_d;

  // Signed difference at RAW_W+1 bits: the MSB is the borrow, i.e. a negative result.
  logic [RAW_W:0]      diff_s;
  assign diff_s = {1'b0, sar_result_i} - {{(RAW_W + 1 - DITHER_W){1'b0}}, dither_q};

  // State register and registered outputs.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      dither_q    <= {DITHER_W{1'b0}};
      busy_q      <= 1'b0;
      lfsr_en_q   <= 1'b0;
      dac_q       <= {DITHER_W{1'b0}};
      sar_start_q <= 1'b0;
      result_q    <= {RES_W{1'b0}};
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dither_q    <= dither_d;
      busy_q      <= busy_d;
      lfsr_en_q   <= lfsr_en_d;
      dac_q       <= dac_d;
      sar_start_q <= sar_start_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      sat_q       <= sat_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state and output decode; the strobes default low so they last one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dither_d    = dither_q;
    busy_d      = busy_q;
    lfsr_en_d   = 1'b0;
    dac_d       = dac_q;
    sar_start_d = 1'b0;
    result_d    = result_q;
    valid_d     = 1'b0;
    sat_d       = sat_q;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dither_d    = dither_en_i ? lfsr_val_i : {DITHER_W{1'b0}};
          dac_d       = dither_en_i ? lfsr_val_i : {DITHER_W{1'b0}};
          busy_d      = 1'b1;
          sar_start_d = 1'b1;
          lfsr_en_d   = dither_en_i;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // A done pulse takes priority over a timeout that expires in the same cycle.
        if (sar_done_i) begin
          if (diff_s[RAW_W]) begin
            result_d = {RES_W{1'b0}};
            sat_d    = 1'b1;
          end else if (|diff_s[RAW_W-1:RES_W]) begin
            result_d = RES_MAX;
            sat_d    = 1'b1;
          end else begin
            result_d = diff_s[RES_W-1:0];
            sat_d    = 1'b0;
          end
          valid_d = 1'b1;
          busy_d  = 1'b0;
          dac_d   = {DITHER_W{1'b0}};
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          dac_d     = {DITHER_W{1'b0}};
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        dac_d   = {DITHER_W{1'b0}};
      end
    endcase
  end

  assign busy_o       = busy_q;
  assign lfsr_en_o    = lfsr_en_q;
  assign dac_dither_o = dac_q;
  assign sar_start_o  = sar_start_q;
  assign result_o     = result_q;
  assign valid_o      = valid_q;
  assign sat_o        = sat_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_saradc_11b_dig_dither_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for saradc_11b_dig_dither_ctrl.
// The bench contains a transaction-level reference model. It predicts every
// output for every cycle and is compared against the DUT on each falling edge.
// Directed vectors with hand-computed literals pin the model itself.
// -----------------------------------------------------------------------------
module tb_saradc_11b_dig_dither_ctrl;

  localparam int RES_W       = 11;
  localparam int RAW_W       = 12;
  localparam int DITHER_W    = 6;
  localparam int TIMEOUT_CYC = 64;
  localparam int RES_MAX     = (1 << RES_W) - 1;

  logic                clk          = 1'b0;
  logic                nres         = 1'b0;
  logic                start_i      = 1'b0;
  logic                dither_en_i  = 1'b0;
  logic                busy_o;
  logic                lfsr_en_o;
  logic [DITHER_W-1:0] lfsr_val_i   = '0;
  logic [DITHER_W-1:0] dac_dither_o;
  logic                sar_start_o;
  logic                sar_done_i   = 1'b0;
  logic [RAW_W-1:0]    sar_result_i = '0;
  logic [RES_W-1:0]    result_o;
  logic                valid_o;
  logic                sat_o;
  logic                timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  saradc_11b_dig_dither_ctrl #(
    .RES_W(RES_W), .RAW_W(RAW_W), .DITHER_W(DITHER_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .nres(nres), .start_i(start_i), .dither_en_i(dither_en_i),
    .busy_o(busy_o), .lfsr_en_o(lfsr_en_o), .lfsr_val_i(lfsr_val_i),
    .dac_dither_o(dac_dither_o), .sar_start_o(sar_start_o),
    .sar_done_i(sar_done_i), .sar_result_i(sar_result_i),
    .result_o(result_o), .valid_o(valid_o), .sat_o(sat_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec arithmetic) ----------------
  function automatic int corrected(input int raw, input int dith);
    int d = raw - dith;
    if (d < 0) return 0;
    if (d > RES_MAX) return RES_MAX;
    return d;
  endfunction

  function automatic bit saturated(input int raw, input int dith);
    return ((raw - dith) < 0) || ((raw - dith) > RES_MAX);
  endfunction

  bit m_active = 1'b0;
  int m_wait   = 0;
  int m_dither = 0;
  bit e_busy = 0, e_lfsr_en = 0, e_sar_start = 0, e_valid = 0, e_sat = 0, e_timeout = 0;
  int e_dac = 0, e_result = 0;

  // Predict the outputs that will be visible after this edge.
  always @(posedge clk or negedge nres) begin
    if (!nres) begin
      m_active <= 0; m_wait <= 0; m_dither <= 0;
      e_busy <= 0; e_lfsr_en <= 0; e_sar_start <= 0; e_valid <= 0;
      e_sat <= 0; e_timeout <= 0; e_dac <= 0; e_result <= 0;
    end else begin
      e_lfsr_en <= 0; e_sar_start <= 0; e_valid <= 0; e_timeout <= 0;
      if (!m_active) begin
        if (start_i) begin
          m_active    <= 1;
          m_wait      <= 0;
          m_dither    <= dither_en_i ? int'(lfsr_val_i) : 0;
          e_dac       <= dither_en_i ? int'(lfsr_val_i) : 0;
          e_busy      <= 1;
          e_sar_start <= 1;
          e_lfsr_en   <= dither_en_i;
        end
      end else begin
        m_wait <= m_wait + 1;
        if (sar_done_i) begin
          e_result <= corrected(int'(sar_result_i), m_dither);
          e_sat    <= saturated(int'(sar_result_i), m_dither);
          e_valid  <= 1;
          m_active <= 0; e_busy <= 0; e_dac <= 0;
        end else if (m_wait + 1 == TIMEOUT_CYC) begin
          e_timeout <= 1;
          m_active  <= 0; e_busy <= 0; e_dac <= 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("busy_o",       busy_o,       e_busy);
    chk("lfsr_en_o",    lfsr_en_o,    e_lfsr_en);
    chk("dac_dither_o", dac_dither_o, e_dac);
    chk("sar_start_o",  sar_start_o,  e_sar_start);
    chk("result_o",     result_o,     e_result);
    chk("valid_o",      valid_o,      e_valid);
    chk("sat_o",        sat_o,        e_sat);
    chk("timeout_o",    timeout_o,    e_timeout);
  end

  // ---------------- directed stimulus ----------------
  task automatic do_conv(input logic en, input logic [5:0] lfsr, input logic [11:0] raw,
                         input int k, input int exp_res, input int exp_sat);
    @(negedge clk); #1;
    start_i = 1'b1; dither_en_i = en; lfsr_val_i = lfsr;
    @(negedge clk); #1;
    start_i = 1'b0; dither_en_i = 1'b0; lfsr_val_i = lfsr + 6'd1;
    chk("d_sar_start", sar_start_o, 1);
    chk("d_lfsr_en",   lfsr_en_o,   en);
    chk("d_dac",       dac_dither_o, en ? lfsr : 6'd0);
    chk("d_busy",      busy_o,      1);
    repeat (k - 1) @(negedge clk);
    #1; sar_done_i = 1'b1; sar_result_i = raw;
    @(negedge clk); #1;
    sar_done_i = 1'b0;
    chk("d_valid",   valid_o,      1);
    chk("d_result",  result_o,     exp_res);
    chk("d_sat",     sat_o,        exp_sat);
    chk("d_timeout", timeout_o,    0);
    chk("d_busy_end", busy_o,      0);
    chk("d_dac_end", dac_dither_o, 0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy_o, 0);       chk("rst_lfsr_en", lfsr_en_o, 0);
    chk("rst_dac", dac_dither_o, 0);  chk("rst_sar_start", sar_start_o, 0);
    chk("rst_result", result_o, 0);   chk("rst_valid", valid_o, 0);
    chk("rst_sat", sat_o, 0);         chk("rst_timeout", timeout_o, 0);
    nres = 1'b1;

    // Basic conversion with dither, dither disabled, both saturation directions.
    do_conv(1'b1, 6'd63, 12'd1063, 3, 1000, 0);
    do_conv(1'b0, 6'd17, 12'd1500, 5, 1500, 0);
    do_conv(1'b1, 6'd63, 12'd40,   2, 0,    1);
    do_conv(1'b1, 6'd20, 12'd2100, 4, 2047, 1);

    // Timeout with no done: pulse after 64 WAIT cycles, result held.
    @(negedge clk); #1;
    start_i = 1'b1; dither_en_i = 1'b1; lfsr_val_i = 6'd5;
    @(negedge clk); #1;
    start_i = 1'b0; dither_en_i = 1'b0;
    chk("to_busy", busy_o, 1);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    #1;
    chk("to_early", timeout_o, 0);
    chk("to_busy_last", busy_o, 1);
    @(negedge clk); #1;
    chk("to_pulse", timeout_o, 1);
    chk("to_busy_end", busy_o, 0);
    chk("to_valid", valid_o, 0);
    chk("to_result_held", result_o, 2047);
    chk("to_sat_held", sat_o, 1);
    chk("to_dac", dac_dither_o, 0);
    @(negedge clk); #1;
    chk("to_one_cycle", timeout_o, 0);

    // Done on the 64th WAIT cycle takes priority over the timeout.
    do_conv(1'b1, 6'd10, 12'd510, TIMEOUT_CYC, 500, 0);

    // A stray done while idle is ignored.
    @(negedge clk); #1;
    sar_done_i = 1'b1; sar_result_i = 12'd4000;
    @(negedge clk); #1;
    sar_done_i = 1'b0;
    chk("stray_valid", valid_o, 0);
    chk("stray_result", result_o, 500);
    chk("stray_busy", busy_o, 0);

    // start_i held through WAIT: one launch per conversion, then back-to-back accept.
    start_i = 1'b1; dither_en_i = 1'b1; lfsr_val_i = 6'd7;
    @(negedge clk); #1;
    chk("hold_launch", sar_start_o, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("hold_no_relaunch", sar_start_o, 0);
    sar_done_i = 1'b1; sar_result_i = 12'd1007;
    @(negedge clk); #1;
    sar_done_i = 1'b0;
    chk("hold_valid", valid_o, 1);
    chk("hold_result", result_o, 1000);
    @(negedge clk); #1;
    chk("b2b_launch", sar_start_o, 1);
    chk("b2b_busy", busy_o, 1);
    chk("b2b_no_valid", valid_o, 0);
    start_i = 1'b0; dither_en_i = 1'b0;
    sar_done_i = 1'b1; sar_result_i = 12'd100;
    @(negedge clk); #1;
    sar_done_i = 1'b0;
    chk("b2b_valid", valid_o, 1);
    chk("b2b_result", result_o, 93);

    // Reset in the middle of WAIT: outputs clear immediately, a late done is ignored.
    @(negedge clk); #1;
    start_i = 1'b1; dither_en_i = 1'b1; lfsr_val_i = 6'd33;
    @(negedge clk); #1;
    start_i = 1'b0; dither_en_i = 1'b0;
    repeat (2) @(negedge clk);
    #2; nres = 1'b0;
    #1;
    chk("mr_busy", busy_o, 0);       chk("mr_dac", dac_dither_o, 0);
    chk("mr_result", result_o, 0);   chk("mr_sat", sat_o, 0);
    chk("mr_valid", valid_o, 0);     chk("mr_timeout", timeout_o, 0);
    @(negedge clk); #1;
    nres = 1'b1;
    sar_done_i = 1'b1; sar_result_i = 12'd999;
    @(negedge clk); #1;
    sar_done_i = 1'b0;
    chk("mr_late_done", valid_o, 0);
    chk("mr_late_result", result_o, 0);

    // Boundaries: zero difference, and exactly full scale without saturation.
    do_conv(1'b1, 6'd1, 12'd1,    2, 0,    0);
    do_conv(1'b1, 6'd1, 12'd2048, 1, 2047, 0);

    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
